// File: rtl/alu16_nibble_serial_if.sv
// Request/response bundle for the nibble-serial ALU sequencer.
// The master issues start/op/a/b and observes status, result and flags.
interface alu16_nibble_serial_if;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        overflow;
  logic        zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, overflow, zero
  );
endinterface

// File: rtl/alu16_nibble_serial.sv
// Nibble-serial 16-bit ALU: one shared 4-bit slice runs over four cycles,
// with the slice carry chained through a register between nibbles.
// Result and flags are registered on entry to DONE and held until the next
// accepted operation completes.
module alu16_nibble_serial (
  input  logic                  clk,
  input  logic                  reset,
  alu16_nibble_serial_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [1:0]  state_reg;
  logic [1:0]  idx_reg;
  logic        carry_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [2:0]  op_reg;
  logic [15:0] acc_reg;
  logic [15:0] acc_next;
  logic [15:0] result_reg;
  logic        cout_reg;
  logic        overflow_reg;
  logic        zero_reg;

  // 4-bit slice signals
  logic [3:0]  slice_a;
  logic [3:0]  slice_b;
  logic [3:0]  slice_b_eff;
  logic [2:0]  slice_op;
  logic        slice_cin;
  logic        slice_less;
  logic [4:0]  slice_sum;
  logic [3:0]  slice_res;
  logic        slice_cout;
  logic        slice_set;

  // Final-value computation at the last nibble
  logic [15:0] result_next;
  logic        cout_next;
  logic        overflow_next;

  // Slice: adder with optional B inversion plus AND/OR/SLT-style output select
  always_comb begin
    slice_a     = a_reg[{idx_reg, 2'b00} +: 4];
    slice_b     = b_reg[{idx_reg, 2'b00} +: 4];
    slice_op    = (op_reg == OP_SLT) ? OP_SUB : op_reg;
    slice_cin   = (idx_reg == 2'd0) ? op_reg[2] : carry_reg;
    slice_less  = 1'b0;
    slice_b_eff = slice_op[2] ? ~slice_b : slice_b;
    slice_sum   = {1'b0, slice_a} + {1'b0, slice_b_eff} + {4'b0000, slice_cin};
    slice_cout  = slice_sum[4];
    slice_set   = slice_sum[3];
    case (slice_op[1:0])
      2'b00:   slice_res = slice_a & slice_b;
      2'b01:   slice_res = slice_a | slice_b;
      2'b10:   slice_res = slice_sum[3:0];
      default: slice_res = {3'b000, slice_less};
    endcase
  end

  // Accumulator: the active nibble takes the slice output, the others hold
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_acc
      assign acc_next[4*gi +: 4] =
        ((state_reg == ST_EXEC) && (idx_reg == 2'(gi))) ? slice_res : acc_reg[4*gi +: 4];
    end
  endgenerate

  // Result and flags as they will be registered when the last nibble finishes
  always_comb begin
    result_next   = 16'h0000;
    cout_next     = 1'b0;
    overflow_next = 1'b0;
    case (op_reg)
      OP_AND, OP_OR: result_next = acc_next;
      OP_ADD: begin
        result_next   = acc_next;
        cout_next     = slice_cout;
        overflow_next = (a_reg[15] == b_reg[15]) && (acc_next[15] != a_reg[15]);
      end
      OP_SUB: begin
        result_next   = acc_next;
        cout_next     = slice_cout;
        overflow_next = (a_reg[15] != b_reg[15]) && (acc_next[15] != a_reg[15]);
      end
      OP_SLT: begin
        // raw sign of A-B, no overflow correction
        result_next = {15'b0, slice_set};
        cout_next   = slice_cout;
      end
      default: result_next = 16'h0000;
    endcase
  end

  // Sequencer: accept in IDLE/DONE, step one nibble per cycle in EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= 2'd0;
      carry_reg    <= 1'b0;
      a_reg        <= 16'h0000;
      b_reg        <= 16'h0000;
      op_reg       <= 3'b000;
      acc_reg      <= 16'h0000;
      result_reg   <= 16'h0000;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_EXEC: begin
          acc_reg   <= acc_next;
          carry_reg <= slice_cout;
          idx_reg   <= idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            state_reg    <= ST_DONE;
            result_reg   <= result_next;
            cout_reg     <= cout_next;
            overflow_reg <= overflow_next;
            zero_reg     <= (result_next == 16'h0000);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            op_reg    <= bus.op;
            idx_reg   <= 2'd0;
            acc_reg   <= 16'h0000;
            state_reg <= ST_EXEC;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy     = (state_reg == ST_EXEC);
  assign bus.done     = (state_reg == ST_DONE);
  assign bus.result   = result_reg;
  assign bus.cout     = cout_reg;
  assign bus.overflow = overflow_reg;
  assign bus.zero     = zero_reg;

endmodule

// File: tb/tb_alu16_nibble_serial.sv
// Directed bench for the nibble-serial ALU: hand-computed vectors, latency,
// ignored start, reset abort, back-to-back and reset in the done cycle.
module tb_alu16_nibble_serial;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alu16_nibble_serial_if bus ();

  alu16_nibble_serial dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for done; lat counts edges after the start edge
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op=%b a=%h b=%h -> result=%h cout=%b ovf=%b zero=%b lat=%0d",
             op, a, b, bus.result, bus.cout, bus.overflow, bus.zero, lat);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done); end
    checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h expected 0000", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {bus.cout, bus.overflow, bus.zero}); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    int lat;
    issue(3'b010, 16'h1234, 16'h4321, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add1_latency got %0d expected 4", lat); end
    checks++; if (bus.result !== 16'h5555) begin errors++; $display("FAIL add1_result got %h expected 5555", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin errors++; $display("FAIL add1_flags got %b expected 000", {bus.cout, bus.overflow, bus.zero}); end
    issue(3'b010, 16'hFFFF, 16'h0001, lat);
    checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL add2_result got %h expected 0000", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b101) begin errors++; $display("FAIL add2_flags got %b expected 101", {bus.cout, bus.overflow, bus.zero}); end
  endtask

  task automatic test_sub;
    int lat;
    issue(3'b110, 16'h8000, 16'h0001, lat);
    checks++; if (bus.result !== 16'h7FFF) begin errors++; $display("FAIL sub1_result got %h expected 7fff", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b110) begin errors++; $display("FAIL sub1_flags got %b expected 110", {bus.cout, bus.overflow, bus.zero}); end
    issue(3'b110, 16'h0005, 16'h0005, lat);
    checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL sub2_result got %h expected 0000", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b101) begin errors++; $display("FAIL sub2_flags got %b expected 101", {bus.cout, bus.overflow, bus.zero}); end
  endtask

  task automatic test_slt;
    int lat;
    issue(3'b111, 16'h0003, 16'h0005, lat);
    checks++; if (bus.result !== 16'h0001) begin errors++; $display("FAIL slt1_result got %h expected 0001", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin errors++; $display("FAIL slt1_flags got %b expected 000", {bus.cout, bus.overflow, bus.zero}); end
    issue(3'b111, 16'h0005, 16'h0003, lat);
    checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL slt2_result got %h expected 0000", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b101) begin errors++; $display("FAIL slt2_flags got %b expected 101", {bus.cout, bus.overflow, bus.zero}); end
  endtask

  task automatic test_logic;
    int lat;
    issue(3'b000, 16'hF0F0, 16'h3C3C, lat);
    checks++; if (bus.result !== 16'h3030) begin errors++; $display("FAIL and_result got %h expected 3030", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin errors++; $display("FAIL and_flags got %b expected 000", {bus.cout, bus.overflow, bus.zero}); end
    issue(3'b001, 16'hF0F0, 16'h3C3C, lat);
    checks++; if (bus.result !== 16'hFCFC) begin errors++; $display("FAIL or_result got %h expected fcfc", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin errors++; $display("FAIL or_flags got %b expected 000", {bus.cout, bus.overflow, bus.zero}); end
  endtask

  task automatic test_invalid;
    int lat;
    issue(3'b100, 16'hFFFF, 16'hFFFF, lat);
    checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL invalid_result got %h expected 0000", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b001) begin errors++; $display("FAIL invalid_flags got %b expected 001", {bus.cout, bus.overflow, bus.zero}); end
  endtask

  // Start pulsed while busy is ignored; outputs hold the previous result during EXEC
  task automatic test_ignore_start;
    int lat;
    // previous op leaves OR result FCFC
    issue(3'b001, 16'hF0F0, 16'h3C3C, lat);
    bus.op = 3'b010; bus.a = 16'h1111; bus.b = 16'h2222; bus.start = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b expected 1", bus.busy); end
    bus.op = 3'b110; bus.a = 16'h9999; bus.b = 16'h0001; // ignored request
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.result !== 16'hFCFC) begin errors++; $display("FAIL ign_hold_result got %h expected fcfc", bus.result); end
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op=010 a=1111 b=2222 (start ignored mid-op) -> result=%h lat=%0d", bus.result, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ign_latency got %0d expected 4", lat); end
    checks++; if (bus.result !== 16'h3333) begin errors++; $display("FAIL ign_result got %h expected 3333", bus.result); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL ign_done_pulse got %b expected 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_no_requeue got %b expected 0", bus.busy); end
  endtask

  // Reset at idx 2 aborts with no done
  task automatic test_reset_abort;
    int done_seen;
    bus.op = 3'b010; bus.a = 16'h1234; bus.b = 16'h4321; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    $display("reset at idx 2 -> busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", bus.busy); end
    checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL abort_result got %h expected 0000", bus.result); end
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1) done_seen++;
      @(posedge clk); #1;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d done cycles expected 0", done_seen); end
  endtask

  // Start during the done cycle is accepted with no idle gap
  task automatic test_back_to_back;
    int lat;
    issue(3'b010, 16'h7FFF, 16'h0001, lat);
    checks++; if (bus.result !== 16'h8000) begin errors++; $display("FAIL b2b1_result got %h expected 8000", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b010) begin errors++; $display("FAIL b2b1_flags got %b expected 010", {bus.cout, bus.overflow, bus.zero}); end
    issue(3'b110, 16'h0003, 16'h0005, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b2_latency got %0d expected 4", lat); end
    checks++; if (bus.result !== 16'hFFFE) begin errors++; $display("FAIL b2b2_result got %h expected fffe", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin errors++; $display("FAIL b2b2_flags got %b expected 000", {bus.cout, bus.overflow, bus.zero}); end
    // issue() above started in the previous done cycle; check busy rose right away
    bus.op = 3'b000; bus.a = 16'h00FF; bus.b = 16'h0F0F; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap got %b expected 1", bus.busy); end
    checks++; if (bus.result !== 16'hFFFE) begin errors++; $display("FAIL b2b_hold got %h expected fffe", bus.result); end
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op=000 a=00ff b=0f0f (back-to-back) -> result=%h lat=%0d", bus.result, lat);
    checks++; if (bus.result !== 16'h000F) begin errors++; $display("FAIL b2b3_result got %h expected 000f", bus.result); end
  endtask

  // Reset in the done cycle clears result and flags
  task automatic test_reset_in_done;
    int lat;
    issue(3'b010, 16'hFFFF, 16'h0001, lat);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset in done -> done=%b result=%h flags=%b", bus.done, bus.result, {bus.cout, bus.overflow, bus.zero});
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rdone_done got %b expected 0", bus.done); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin errors++; $display("FAIL rdone_flags got %b expected 000", {bus.cout, bus.overflow, bus.zero}); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.a = 16'h0000;
    bus.b = 16'h0000;
    reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_invalid();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_reset_in_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu16_nibble_serial.md
# alu16_nibble_serial

Nibble-serial 16-bit ALU sequencer. It executes one 16-bit AND/OR/ADD/SUB/SLT operation over four clock cycles. Each cycle it drives one 4-bit nibble of the latched operands through a single internal `ALU4Bit` slice. Between cycles it carries the slice's `cout` forward as the next nibble's `cin`, and it assembles result, carry, overflow and zero flags. It sits between the datapath register file and writeback, trading latency for one shared 4-bit slice instead of four.

## Interface
Parameters: none. Width is fixed at 16 bits, processed as 4 nibbles.

- `clk` input 1 — single clock; all state updates on rising edge.
- `reset` input 1 — synchronous, active-high; sampled on rising edge of `clk`.
- `start` input 1 — request; sampled only in IDLE or DONE.
- `op` input 3 — operation code, sampled with `start`:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB
  - 111 SLT
  - any other code is invalid
- `a` input 16 — operand A, sampled with `start`.
- `b` input 16 — operand B, sampled with `start`.
- `busy` output 1 — high while in EXEC.
- `done` output 1 — one-cycle pulse; result and flags are valid in this cycle.
- `result` output 16 — registered result; held until the next accepted `start` completes.
- `cout` output 1 — registered carry-out of nibble 3; ADD/SUB/SLT only, else 0.
- `overflow` output 1 — registered signed overflow; ADD/SUB only, else 0.
- `zero` output 1 — registered; 1 iff the final `result` == 16'h0000.

## Operation
States: IDLE, EXEC, DONE.

- **IDLE/DONE with `start`=1:** latch `a`, `b` and `op`; clear the nibble index `idx` to 0; clear the result accumulator; go to EXEC.
- **IDLE/DONE with `start`=0:** DONE goes to IDLE; IDLE stays in IDLE.
- **`start` while in EXEC:** ignored. No queueing; the latched operands are unchanged.

Slice connection (combinational from registers):
- `a`/`b` nibble inputs = latched `a`/`b` bits [4·idx+3 : 4·idx].
- `less` tied 0.
- `op`: the latched op, except SLT drives 110 to the slice.
- `cin`: at idx 0 = `op[2]` (1 for SUB/SLT, 0 otherwise); at idx > 0 = the carry register.

EXEC, each edge:
- Write the slice `result` into accumulator nibble idx.
- Carry register ← slice `cout`.
- idx ← idx+1.
- At idx 3: capture slice `set` and `cout`, then go to DONE.

Entering DONE, the outputs are registered as follows:
- **`result`:**
  - AND/OR/ADD/SUB: the assembled accumulator.
  - SLT: {15'b0, set}, where set is the raw sign bit of A−B; no overflow correction, consistent with the slice convention.
  - Invalid op: 16'h0000.
- **`cout`:** nibble-3 carry for ADD/SUB/SLT; 0 otherwise.
- **`overflow`:**
  - ADD: (a[15]==b[15]) && (sum[15]!=a[15]).
  - SUB: (a[15]!=b[15]) && (diff[15]!=a[15]).
  - All other ops: 0.
- **`zero`:** evaluated on the final `result` value, including SLT and invalid ops.

## Timing
- Reset values: state IDLE, idx 0, carry 0, `busy` 0, `done` 0, `result` 16'h0000, `cout` 0, `overflow` 0, `zero` 0.
- Latency: `start` sampled at edge k → `busy`=1 after edges k..k+3 → `done`=1 for exactly the cycle after edge k+4.
- Back-to-back: `start` may be asserted during the `done` cycle. It is accepted at edge k+5, and `busy` rises with no idle gap. Throughput is one op per 5 cycles.
- `result`, `cout`, `overflow` and `zero` change only on entry to DONE (or on reset); they are stable at all other times, including throughout EXEC.
- `reset` in EXEC: at the next edge the block returns to IDLE and all outputs take their reset values. The aborted operation produces no `done`. `reset` wins over a simultaneous `start`.
- `reset` during the `done` cycle: the block returns to IDLE, and `result`/flags clear at that edge.

## Test plan
- ADD 0x1234+0x4321 → `result` 0x5555, `cout` 0, `overflow` 0, `zero` 0; `done` exactly 4 edges after the `start` edge.
- ADD 0xFFFF+0x0001 → `result` 0x0000, `cout` 1, `overflow` 0, `zero` 1. This confirms carry propagation across all nibbles.
- SUB 0x8000−0x0001 → `result` 0x7FFF, `cout` 1, `overflow` 1.
- SUB 0x0005−0x0005 → `result` 0x0000, `zero` 1, `cout` 1.
- SLT 0x0003,0x0005 → `result` 0x0001, `zero` 0.
- SLT 0x0005,0x0003 → `result` 0x0000, `zero` 1.
- AND 0xF0F0,0x3C3C → `result` 0x3030, with `cout`/`overflow` 0.
- OR 0xF0F0,0x3C3C → `result` 0xFCFC, with `cout`/`overflow` 0.
- Issue ADD, pulse `start` with new operands while `busy`=1 → the second request is ignored and the first completes. Assert `reset` at idx 2 of a new op → `busy` 0 and `result` 0 next cycle, with no `done`. Back-to-back `start` during `done` → accepted with no gap.
